// File: rtl/tilt_move_generator_pkg.sv
// Shared types for the tilt-to-cursor move path: direction codes, the
// move-generator state encoding and a direction-to-pulse helper.
package tilt_move_generator_pkg;

    typedef enum logic [2:0] {
        DIR_NONE  = 3'd0,
        DIR_LEFT  = 3'd1,
        DIR_RIGHT = 3'd2,
        DIR_UP    = 3'd3,
        DIR_DOWN  = 3'd4
    } dir_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        QUALIFY = 2'd1,
        HOLD    = 2'd2,
        REPEAT  = 2'd3
    } tilt_state_t;

    // Pulse vector ordering is {left, right, up, down}.
    function automatic logic [3:0] dir_to_pulse(input dir_t d);
        logic [3:0] v;
        case (d)
            DIR_LEFT:  v = 4'b1000;
            DIR_RIGHT: v = 4'b0100;
            DIR_UP:    v = 4'b0010;
            DIR_DOWN:  v = 4'b0001;
            default:   v = 4'b0000;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/tilt_move_generator_dir_decode.sv
// Combinational tilt decoder: maps signed angles to a single direction with
// fixed priority, letting an already engaged direction stay active down to
// the lower hysteresis threshold on its own axis and sign.
module tilt_move_generator_dir_decode
    import tilt_move_generator_pkg::*;
#(
    parameter int THRESHOLD  = 30,
    parameter int HYSTERESIS = 5
) (
    input  logic signed [8:0] i_angle_x,
    input  logic signed [8:0] i_angle_y,
    input  dir_t              i_engaged,
    output dir_t              o_raw
);

    // Ten bits so that -THRESHOLD and the full -256..255 input range compare safely.
    localparam logic signed [9:0] ENG_P = 10'(THRESHOLD);
    localparam logic signed [9:0] ENG_N = 10'(-THRESHOLD);
    localparam logic signed [9:0] HLD_P = 10'(THRESHOLD - HYSTERESIS);
    localparam logic signed [9:0] HLD_N = 10'(HYSTERESIS - THRESHOLD);

    logic signed [9:0] w_x;
    logic signed [9:0] w_y;

    assign w_x = {i_angle_x[8], i_angle_x};
    assign w_y = {i_angle_y[8], i_angle_y};

    // Engaged direction first (hysteresis band), then the plain priority decode.
    always_comb begin
        o_raw = DIR_NONE;
        if (i_engaged == DIR_LEFT && w_x >= HLD_P) begin
            o_raw = DIR_LEFT;
        end else if (i_engaged == DIR_RIGHT && w_x <= HLD_N) begin
            o_raw = DIR_RIGHT;
        end else if (i_engaged == DIR_DOWN && w_y >= HLD_P) begin
            o_raw = DIR_DOWN;
        end else if (i_engaged == DIR_UP && w_y <= HLD_N) begin
            o_raw = DIR_UP;
        end else if (w_x > ENG_P) begin
            o_raw = DIR_LEFT;
        end else if (w_x < ENG_N) begin
            o_raw = DIR_RIGHT;
        end else if (w_y > ENG_P) begin
            o_raw = DIR_DOWN;
        end else if (w_y < ENG_N) begin
            o_raw = DIR_UP;
        end
    end

endmodule

// File: rtl/tilt_move_generator.sv
// Tilt move generator: turns CORDIC tilt angles into debounced, hysteretic,
// one-cycle cursor move pulses with auto-repeat while a tilt is held.
module tilt_move_generator
    import tilt_move_generator_pkg::*;
#(
    parameter int THRESHOLD       = 30,
    parameter int HYSTERESIS      = 5,
    parameter int DEBOUNCE_CYCLES = 250_000,
    parameter int REPEAT_DELAY    = 12_500_000,
    parameter int REPEAT_PERIOD   = 5_000_000,
    parameter int CNT_W           = 24
) (
    input  logic              clk,
    input  logic              reset,
    input  logic signed [8:0] angle_x,
    input  logic signed [8:0] angle_y,
    input  logic              enable,
    output logic              left_tilt,
    output logic              right_tilt,
    output logic              up_tilt,
    output logic              down_tilt,
    output dir_t              held_dir
);

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RD_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RP_LAST  = CNT_W'(REPEAT_PERIOD - 1);

    tilt_state_t      r_state;
    tilt_state_t      w_state_nxt;
    dir_t             r_cand;
    dir_t             w_cand_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    dir_t             w_pulse_dir;
    dir_t             w_engaged;
    dir_t             w_raw;
    logic [3:0]       r_pulse;
    dir_t             r_held_dir;

    // Only a direction that has already produced its first pulse gets hysteresis.
    assign w_engaged = (r_state == HOLD || r_state == REPEAT) ? r_cand : DIR_NONE;

    tilt_move_generator_dir_decode #(
        .THRESHOLD  (THRESHOLD),
        .HYSTERESIS (HYSTERESIS)
    ) u_decode (
        .i_angle_x (angle_x),
        .i_angle_y (angle_y),
        .i_engaged (w_engaged),
        .o_raw     (w_raw)
    );

    // Next-state, candidate, counter and pulse selection.
    always_comb begin
        w_state_nxt = r_state;
        w_cand_nxt  = r_cand;
        w_cnt_nxt   = r_cnt + 1'b1;
        w_pulse_dir = DIR_NONE;
        if (!enable) begin
            w_state_nxt = IDLE;
            w_cand_nxt  = DIR_NONE;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    w_cnt_nxt = '0;
                    if (w_raw != DIR_NONE) begin
                        w_state_nxt = QUALIFY;
                        w_cand_nxt  = w_raw;
                    end
                end
                QUALIFY: begin
                    if (w_raw == DIR_NONE) begin
                        w_state_nxt = IDLE;
                        w_cand_nxt  = DIR_NONE;
                        w_cnt_nxt   = '0;
                    end else if (w_raw != r_cand) begin
                        w_cand_nxt = w_raw;
                        w_cnt_nxt  = '0;
                    end else if (r_cnt == DEB_LAST) begin
                        w_pulse_dir = r_cand;
                        w_state_nxt = HOLD;
                        w_cnt_nxt   = '0;
                    end
                end
                HOLD, REPEAT: begin
                    if (w_raw != r_cand) begin
                        // Losing the engaged direction never emits a pulse.
                        w_cnt_nxt = '0;
                        if (w_raw == DIR_NONE) begin
                            w_state_nxt = IDLE;
                            w_cand_nxt  = DIR_NONE;
                        end else begin
                            w_state_nxt = QUALIFY;
                            w_cand_nxt  = w_raw;
                        end
                    end else if (r_cnt == ((r_state == HOLD) ? RD_LAST : RP_LAST)) begin
                        w_pulse_dir = r_cand;
                        w_state_nxt = REPEAT;
                        w_cnt_nxt   = '0;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_cand_nxt  = DIR_NONE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    // State, counter and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_cand     <= DIR_NONE;
            r_cnt      <= '0;
            r_pulse    <= 4'b0000;
            r_held_dir <= DIR_NONE;
        end else begin
            r_state    <= w_state_nxt;
            r_cand     <= w_cand_nxt;
            r_cnt      <= w_cnt_nxt;
            r_pulse    <= dir_to_pulse(w_pulse_dir);
            r_held_dir <= (w_state_nxt == HOLD || w_state_nxt == REPEAT) ? w_cand_nxt : DIR_NONE;
        end
    end

    assign left_tilt  = r_pulse[3];
    assign right_tilt = r_pulse[2];
    assign up_tilt    = r_pulse[1];
    assign down_tilt  = r_pulse[0];
    assign held_dir   = r_held_dir;

endmodule

// File: tb/tb_tilt_move_generator.sv
// Bench for tilt_move_generator: directed tilt sequences push expected move
// pulses (cycle, direction) into a queue; a monitor pops and compares them.
`timescale 1ns/1ps
module tb_tilt_move_generator;
    import tilt_move_generator_pkg::*;

    logic              clk = 1'b0;
    logic              reset;
    logic signed [8:0] angle_x;
    logic signed [8:0] angle_y;
    logic              enable;
    logic              left_tilt;
    logic              right_tilt;
    logic              up_tilt;
    logic              down_tilt;
    dir_t              held_dir;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        int         at;
        logic [3:0] vec;
    } exp_t;

    exp_t q[$];

    localparam logic [3:0] P_L = 4'b1000;
    localparam logic [3:0] P_R = 4'b0100;
    localparam logic [3:0] P_U = 4'b0010;
    localparam logic [3:0] P_D = 4'b0001;

    tilt_move_generator #(
        .THRESHOLD       (30),
        .HYSTERESIS      (5),
        .DEBOUNCE_CYCLES (4),
        .REPEAT_DELAY    (10),
        .REPEAT_PERIOD   (3),
        .CNT_W           (24)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .angle_x    (angle_x),
        .angle_y    (angle_y),
        .enable     (enable),
        .left_tilt  (left_tilt),
        .right_tilt (right_tilt),
        .up_tilt    (up_tilt),
        .down_tilt  (down_tilt),
        .held_dir   (held_dir)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input int at, input logic [3:0] v);
        exp_t e;
        e.at  = at;
        e.vec = v;
        q.push_back(e);
    endtask

    task automatic chk_held(input string nm, input dir_t exp);
        checks++;
        if (held_dir !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d held_dir=%0d required=%0d", nm, cyc, held_dir, exp);
        end
    endtask

    task automatic chk_pulses(input string nm, input logic [3:0] exp);
        checks++;
        if ({left_tilt, right_tilt, up_tilt, down_tilt} !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d pulses=%b required=%b", nm, cyc,
                     {left_tilt, right_tilt, up_tilt, down_tilt}, exp);
        end
    endtask

    // Monitor: every pulse must match the next queued expectation exactly.
    always @(negedge clk) begin
        logic [3:0] pv;
        exp_t       e;
        pv = {left_tilt, right_tilt, up_tilt, down_tilt};
        while (q.size() > 0 && q[0].at < cyc) begin
            checks++;
            errors++;
            $display("FAIL missing_pulse cycle=%0d actual=none required=%b", q[0].at, q[0].vec);
            void'(q.pop_front());
        end
        if (pv != 4'b0000) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse cycle=%0d actual=%b required=none", cyc, pv);
            end else begin
                e = q.pop_front();
                if (e.at != cyc || e.vec != pv) begin
                    errors++;
                    $display("FAIL pulse cycle=%0d actual=%b required=%b@%0d", cyc, pv, e.vec, e.at);
                end
            end
        end
    end

    initial begin
        int c;
        reset   = 1'b1;
        enable  = 1'b1;
        angle_x = 9'sd40;
        angle_y = 9'sd0;

        // Reset held with a tilt present, then first pulse after full debounce.
        step(3);
        chk_pulses("reset_pulses", 4'b0000);
        chk_held("reset_held", DIR_NONE);
        c = cyc;
        reset = 1'b0;
        push(c + 5, P_L);
        step(6);
        chk_held("first_hold", DIR_LEFT);
        angle_x = 9'sd0;
        step(1);
        chk_held("first_release", DIR_NONE);
        step(3);

        // Too-short tilt: no pulse.
        angle_x = 9'sd40;
        step(3);
        angle_x = 9'sd0;
        step(6);
        chk_held("short_tilt", DIR_NONE);

        // Held tilt: first pulse, delayed repeat, then periodic repeats.
        c = cyc;
        angle_x = 9'sd40;
        push(c + 5, P_L);
        push(c + 15, P_L);
        push(c + 18, P_L);
        push(c + 21, P_L);
        push(c + 24, P_L);
        push(c + 27, P_L);
        push(c + 30, P_L);
        step(20);
        chk_held("repeat_left", DIR_LEFT);
        step(10);
        angle_x = 9'sd0;
        step(1);
        chk_held("repeat_release", DIR_NONE);
        step(4);

        // Hysteresis: 27 keeps LEFT engaged, 24 drops it before the next repeat.
        c = cyc;
        angle_x = 9'sd40;
        push(c + 5, P_L);
        step(6);
        angle_x = 9'sd27;
        push(c + 15, P_L);
        push(c + 18, P_L);
        push(c + 21, P_L);
        push(c + 24, P_L);
        step(20);
        chk_held("hyst_hold", DIR_LEFT);
        angle_x = 9'sd24;
        step(1);
        chk_held("hyst_drop", DIR_NONE);
        angle_x = 9'sd0;
        step(3);

        // Priority then switch to DOWN with re-debounce.
        c = cyc;
        angle_x = 9'sd40;
        angle_y = 9'sd40;
        push(c + 5, P_L);
        step(6);
        angle_x = 9'sd0;
        push(c + 11, P_D);
        step(5);
        chk_held("switch_down", DIR_DOWN);
        angle_y = 9'sd0;
        step(3);

        // enable=0 in REPEAT suppresses the due pulse; re-debounce afterwards.
        c = cyc;
        angle_x = 9'sd40;
        push(c + 5, P_L);
        push(c + 15, P_L);
        step(17);
        enable = 1'b0;
        step(1);
        chk_pulses("enable_off_pulse", 4'b0000);
        chk_held("enable_off_held", DIR_NONE);
        enable = 1'b1;
        push(c + 23, P_L);
        step(5);
        chk_held("enable_rearm", DIR_LEFT);
        angle_x = 9'sd0;
        step(3);

        // Reset in REPEAT behaves the same way.
        c = cyc;
        angle_x = 9'sd40;
        push(c + 5, P_L);
        push(c + 15, P_L);
        step(17);
        reset = 1'b1;
        step(1);
        chk_pulses("reset_mid_pulse", 4'b0000);
        chk_held("reset_mid_held", DIR_NONE);
        reset = 1'b0;
        push(c + 23, P_L);
        step(5);
        chk_held("reset_rearm", DIR_LEFT);
        angle_x = 9'sd0;
        step(3);

        // Most negative angle is a right tilt.
        c = cyc;
        angle_x = 9'h100;
        push(c + 5, P_R);
        step(6);
        chk_held("right_min", DIR_RIGHT);
        angle_x = 9'sd0;
        step(3);

        // Up tilt.
        c = cyc;
        angle_y = -9'sd40;
        push(c + 5, P_U);
        step(6);
        chk_held("up_tilt", DIR_UP);
        angle_y = 9'sd0;
        step(3);

        // Exactly at threshold does not engage.
        angle_x = 9'sd30;
        step(10);
        chk_held("at_threshold", DIR_NONE);
        angle_x = 9'sd0;
        step(3);

        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL leftover_expected actual=%0d required=0", q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
